// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall hold and redirect-squash into a NOP bubble.
module if_stage #(
  parameter int                     ADDR_WIDTH = 9,
  parameter int                     INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [INSN_WIDTH-1:0]  NOP_INSN   = INSN_WIDTH'(32'h0000_0013)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSN_WIDTH-1:0] imem_insn,
  output logic                  if_id_valid,
  output logic [ADDR_WIDTH-1:0] if_id_pc,
  output logic [ADDR_WIDTH-1:0] if_id_pc_plus4,
  output logic [INSN_WIDTH-1:0] if_id_insn,
  output logic                  misaligned_fault,
  output logic [31:0]           fetch_count
);

  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic                  valid_reg, valid_next;
  logic [ADDR_WIDTH-1:0] id_pc_reg, id_pc_next;
  logic [ADDR_WIDTH-1:0] id_pc4_reg, id_pc4_next;
  logic [INSN_WIDTH-1:0] insn_reg, insn_next;
  logic                  fault_reg, fault_next;
  logic [31:0]           count_reg, count_next;

  assign pc_plus4 = pc_reg + ADDR_WIDTH'(4);

  // Redirect outranks stall; the target is forced word-aligned so pc[1:0] stays 00.
  always_comb begin
    pc_next     = pc_reg;
    valid_next  = valid_reg;
    id_pc_next  = id_pc_reg;
    id_pc4_next = id_pc4_reg;
    insn_next   = insn_reg;
    fault_next  = 1'b0;
    count_next  = count_reg;
    if (redirect_valid) begin
      pc_next     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      valid_next  = 1'b0;
      id_pc_next  = '0;
      id_pc4_next = '0;
      insn_next   = NOP_INSN;
      fault_next  = |redirect_pc[1:0];
    end else if (!stall) begin
      pc_next     = pc_plus4;
      valid_next  = 1'b1;
      id_pc_next  = pc_reg;
      id_pc4_next = pc_plus4;
      insn_next   = imem_insn;
      count_next  = count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      valid_reg  <= 1'b0;
      id_pc_reg  <= '0;
      id_pc4_reg <= '0;
      insn_reg   <= NOP_INSN;
      fault_reg  <= 1'b0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      valid_reg  <= valid_next;
      id_pc_reg  <= id_pc_next;
      id_pc4_reg <= id_pc4_next;
      insn_reg   <= insn_next;
      fault_reg  <= fault_next;
      count_reg  <= count_next;
    end
  end

  assign imem_addr        = pc_reg;
  assign if_id_valid      = valid_reg;
  assign if_id_pc         = id_pc_reg;
  assign if_id_pc_plus4   = id_pc4_reg;
  assign if_id_insn       = insn_reg;
  assign misaligned_fault = fault_reg;
  assign fetch_count      = count_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a word-indexed memory model answers imem_addr and each
// scenario task checks IF/ID, PC, fault and count against hand-computed values.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_insn;
  logic        if_id_valid;
  logic [8:0]  if_id_pc;
  logic [8:0]  if_id_pc_plus4;
  logic [31:0] if_id_insn;
  logic        misaligned_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [128];
  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_insn(imem_insn),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_insn(if_id_insn),
    .misaligned_fault(misaligned_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_insn = mem[imem_addr[8:2]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    total++; if (imem_addr !== 9'h000) begin bad++; $display("FAIL reset_addr got=%h exp=000", imem_addr); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_insn !== 32'h13) begin bad++; $display("FAIL reset_insn got=%h exp=00000013", if_id_insn); end
    total++; if (if_id_pc !== 9'h0 || if_id_pc_plus4 !== 9'h0) begin bad++; $display("FAIL reset_pcs got=%h/%h exp=000/000", if_id_pc, if_id_pc_plus4); end
    total++; if (misaligned_fault !== 1'b0 || fetch_count !== 32'd0) begin bad++; $display("FAIL reset_fault_count got=%b/%0d exp=0/0", misaligned_fault, fetch_count); end
    $display("reset: addr=%h valid=%b insn=%h count=%0d", imem_addr, if_id_valid, if_id_insn, fetch_count);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_insn [3];
    exp_insn[0] = 32'h11; exp_insn[1] = 32'h22; exp_insn[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (if_id_insn !== exp_insn[i]) begin bad++; $display("FAIL run_insn%0d got=%h exp=%h", i, if_id_insn, exp_insn[i]); end
      total++; if (if_id_pc !== 9'(4*i) || if_id_pc_plus4 !== 9'(4*i+4)) begin bad++; $display("FAIL run_pc%0d got=%h/%h exp=%h/%h", i, if_id_pc, if_id_pc_plus4, 9'(4*i), 9'(4*i+4)); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL run_valid%0d got=%b exp=1", i, if_id_valid); end
      $display("fetch: pc=%h insn=%h count=%0d", if_id_pc, if_id_insn, fetch_count);
    end
    total++; if (fetch_count !== 32'd3 || imem_addr !== 9'd12) begin bad++; $display("FAIL run_count got=%0d/%h exp=3/00c", fetch_count, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (if_id_pc !== 9'd8 || imem_addr !== 9'd12 || fetch_count !== 32'd3) begin bad++; $display("FAIL stall%0d got pc=%h addr=%h cnt=%0d exp pc=008 addr=00c cnt=3", i, if_id_pc, imem_addr, fetch_count); end
      $display("stall: if_id_pc=%h addr=%h count=%0d", if_id_pc, imem_addr, fetch_count);
    end
    stall = 1'b0;
    step();
    total++; if (if_id_pc !== 9'd12 || if_id_insn !== 32'h1000_0003 || fetch_count !== 32'd4) begin bad++; $display("FAIL stall_release got pc=%h insn=%h cnt=%0d exp pc=00c insn=10000003 cnt=4", if_id_pc, if_id_insn, fetch_count); end
    $display("resume: if_id_pc=%h insn=%h count=%0d", if_id_pc, if_id_insn, fetch_count);
  endtask

  task automatic test_redirect();
    total++; if (imem_addr !== 9'h10) begin bad++; $display("FAIL redir_pre got=%h exp=010", imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 9'h40;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h40 || if_id_valid !== 1'b0 || if_id_insn !== 32'h13) begin bad++; $display("FAIL redir_bubble got addr=%h v=%b insn=%h exp addr=040 v=0 insn=00000013", imem_addr, if_id_valid, if_id_insn); end
    total++; if (fetch_count !== 32'd4 || misaligned_fault !== 1'b0) begin bad++; $display("FAIL redir_cnt got=%0d/%b exp=4/0", fetch_count, misaligned_fault); end
    $display("redirect: addr=%h valid=%b insn=%h", imem_addr, if_id_valid, if_id_insn);
    step();
    total++; if (if_id_pc !== 9'h40 || if_id_valid !== 1'b1 || if_id_insn !== 32'h1000_0010 || if_id_pc_plus4 !== 9'h44) begin bad++; $display("FAIL redir_target got pc=%h v=%b insn=%h p4=%h exp pc=040 v=1 insn=10000010 p4=044", if_id_pc, if_id_valid, if_id_insn, if_id_pc_plus4); end
    $display("target: if_id_pc=%h insn=%h count=%0d", if_id_pc, if_id_insn, fetch_count);
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h80;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h80 || if_id_valid !== 1'b0 || if_id_insn !== 32'h13 || if_id_pc !== 9'h0) begin bad++; $display("FAIL stall_redir got addr=%h v=%b insn=%h pc=%h exp addr=080 v=0 insn=00000013 pc=000", imem_addr, if_id_valid, if_id_insn, if_id_pc); end
    $display("stall+redirect: addr=%h valid=%b", imem_addr, if_id_valid);
    step();
    total++; if (if_id_pc !== 9'h80 || if_id_insn !== 32'h1000_0020 || fetch_count !== 32'd6) begin bad++; $display("FAIL stall_redir_next got pc=%h insn=%h cnt=%0d exp pc=080 insn=10000020 cnt=6", if_id_pc, if_id_insn, fetch_count); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 9'h46;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h44 || misaligned_fault !== 1'b1) begin bad++; $display("FAIL misalign got addr=%h fault=%b exp addr=044 fault=1", imem_addr, misaligned_fault); end
    $display("misaligned: addr=%h fault=%b", imem_addr, misaligned_fault);
    step();
    total++; if (misaligned_fault !== 1'b0 || if_id_pc !== 9'h44 || fetch_count !== 32'd7) begin bad++; $display("FAIL misalign_next got fault=%b pc=%h cnt=%0d exp fault=0 pc=044 cnt=7", misaligned_fault, if_id_pc, fetch_count); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 9'h1F8;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    total++; if (if_id_pc !== 9'h1FC || if_id_pc_plus4 !== 9'h0 || imem_addr !== 9'h0 || if_id_insn !== 32'h1000_007F) begin bad++; $display("FAIL wrap got pc=%h p4=%h addr=%h insn=%h exp pc=1fc p4=000 addr=000 insn=1000007f", if_id_pc, if_id_pc_plus4, imem_addr, if_id_insn); end
    total++; if (fetch_count !== 32'd9) begin bad++; $display("FAIL wrap_cnt got=%0d exp=9", fetch_count); end
    $display("wrap: if_id_pc=%h p4=%h addr=%h", if_id_pc, if_id_pc_plus4, imem_addr);
    step();
    total++; if (if_id_pc !== 9'h0 || if_id_insn !== 32'h11 || fetch_count !== 32'd10) begin bad++; $display("FAIL wrap_next got pc=%h insn=%h cnt=%0d exp pc=000 insn=00000011 cnt=10", if_id_pc, if_id_insn, fetch_count); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 9'h46;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'd0 || misaligned_fault !== 1'b0) begin bad++; $display("FAIL reset_mid got addr=%h v=%b cnt=%0d fault=%b exp addr=000 v=0 cnt=0 fault=0", imem_addr, if_id_valid, fetch_count, misaligned_fault); end
    $display("reset mid-run: addr=%h valid=%b count=%0d", imem_addr, if_id_valid, fetch_count);
  endtask

  task automatic test_back_to_back();
    // Redirect on the very first cycle after reset, then two redirects in a row.
    redirect_valid = 1'b1; redirect_pc = 9'h20;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h20 || fetch_count !== 32'd0) begin bad++; $display("FAIL first_redir got addr=%h cnt=%0d exp addr=020 cnt=0", imem_addr, fetch_count); end
    step();
    total++; if (if_id_pc !== 9'h20 || fetch_count !== 32'd1 || if_id_insn !== 32'h1000_0008) begin bad++; $display("FAIL first_redir_next got pc=%h cnt=%0d insn=%h exp pc=020 cnt=1 insn=10000008", if_id_pc, fetch_count, if_id_insn); end
    redirect_valid = 1'b1; redirect_pc = 9'h100;
    step();
    redirect_pc = 9'h104;
    step();
    redirect_valid = 1'b0;
    total++; if (imem_addr !== 9'h104 || if_id_valid !== 1'b0 || misaligned_fault !== 1'b0) begin bad++; $display("FAIL b2b_redir got addr=%h v=%b fault=%b exp addr=104 v=0 fault=0", imem_addr, if_id_valid, misaligned_fault); end
    step();
    total++; if (if_id_pc !== 9'h104 || if_id_insn !== 32'h1000_0041 || fetch_count !== 32'd2) begin bad++; $display("FAIL b2b_next got pc=%h insn=%h cnt=%0d exp pc=104 insn=10000041 cnt=2", if_id_pc, if_id_insn, fetch_count); end
    $display("back-to-back: if_id_pc=%h insn=%h count=%0d", if_id_pc, if_id_insn, fetch_count);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect();
    test_stall_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
